pro_accum: RTL and testbench

- Sits directly downstream of the worker stage. Snoops the worker's proposal-SRAM write port (pro_wdata / pro_bytemask / pro_waddr / wen) and builds a private 16-row x 16-lane copy of one batch's proposal counts.
- On batch_finish it reduces the 16 rows (one per sub-batch) into per-partition totals and finds the best partition.
- It then presents the result to the partition-update logic through a valid/ready handshake.

---
 rtl/pro_accum_if.sv | 39 +++
 rtl/pro_accum.sv | 136 +++++++++++++
 tb/tb_pro_accum.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pro_accum_if.sv
// rtl/pro_accum_if.sv - worker snoop port and result handshake bundle for pro_accum
//
// Signals:
//   wen, pro_waddr, pro_bytemask, pro_wdata : snooped worker proposal-SRAM write port
//   batch_finish                            : worker batch done pulse
//   out_valid, out_ready                    : result handshake
//   sum_out, best_idx, best_val             : per-lane totals and argmax result
//   busy, drop_err                          : status
// Modports: master = worker/consumer side, slave = pro_accum.
interface pro_accum_if #(
  parameter int Q              = 16,
  parameter int PRO_BW         = 8,
  parameter int PRO_ADDR_SPACE = 4,
  parameter int SUM_BW         = 12,
  parameter int IDX_BW         = 4
);
  logic                      wen;
  logic [PRO_ADDR_SPACE-1:0] pro_waddr;
  logic [Q-1:0]              pro_bytemask;
  logic [Q*PRO_BW-1:0]       pro_wdata;
  logic                      batch_finish;
  logic                      out_valid;
  logic                      out_ready;
  logic [Q*SUM_BW-1:0]       sum_out;
  logic [IDX_BW-1:0]         best_idx;
  logic [SUM_BW-1:0]         best_val;
  logic                      busy;
  logic                      drop_err;

  modport master (
    output wen, pro_waddr, pro_bytemask, pro_wdata, batch_finish, out_ready,
    input  out_valid, sum_out, best_idx, best_val, busy, drop_err
  );

  modport slave (
    input  wen, pro_waddr, pro_bytemask, pro_wdata, batch_finish, out_ready,
    output out_valid, sum_out, best_idx, best_val, busy, drop_err
  );
endinterface

// File: rtl/pro_accum.sv
// rtl/pro_accum.sv - snoops worker proposal writes, reduces rows to per-partition totals, finds argmax
//
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   en    : block enable; low freezes capture and state advance
//   bus   : pro_accum_if.slave (snoop write port, batch_finish, result handshake, status)
//
// Flow: CAP (capture writes) -> SUM (one row per cycle into acc) -> BEST (argmax,
// register results) -> DONE (present until out_ready, then clear and return to CAP).
module pro_accum #(
  parameter int Q              = 16,
  parameter int PRO_BW         = 8,
  parameter int PRO_ADDR_SPACE = 4,
  parameter int SUM_BW         = 12,
  parameter int IDX_BW         = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  pro_accum_if.slave  bus
);
  localparam int ROWS = 1 << PRO_ADDR_SPACE;

  typedef enum logic [1:0] {CAP, SUM, BEST, DONE} state_t;

  state_t                    state, state_nxt;
  logic [Q*PRO_BW-1:0]       mem [ROWS];
  logic [PRO_ADDR_SPACE-1:0] row_cnt;
  logic [Q*SUM_BW-1:0]       acc, acc_nxt;
  logic [Q*SUM_BW-1:0]       sum_q;
  logic [IDX_BW-1:0]         best_idx_q, arg_idx;
  logic [SUM_BW-1:0]         best_val_q, arg_val;
  logic                      out_valid_q;
  logic                      drop_err_q;
  logic                      write;
  logic                      accept;

  assign write  = en && bus.wen && (state == CAP);
  assign accept = en && (state == DONE) && out_valid_q && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CAP;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (en) begin
      case (state)
        CAP:  if (bus.batch_finish) state_nxt = SUM;
        SUM:  if (row_cnt == PRO_ADDR_SPACE'(ROWS - 1)) state_nxt = BEST;
        BEST: state_nxt = DONE;
        DONE: if (out_valid_q && bus.out_ready) state_nxt = CAP;
        default: state_nxt = CAP;
      endcase
    end
  end

  // Per-lane addition of the current row, zero-extended; wraps modulo 2^SUM_BW.
  always_comb begin
    acc_nxt = acc;
    for (int i = 0; i < Q; i++) begin
      acc_nxt[i*SUM_BW +: SUM_BW] = acc[i*SUM_BW +: SUM_BW]
                                  + SUM_BW'(mem[row_cnt][i*PRO_BW +: PRO_BW]);
    end
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    arg_idx = '0;
    arg_val = acc[0 +: SUM_BW];
    for (int i = 1; i < Q; i++) begin
      if (acc[i*SUM_BW +: SUM_BW] > arg_val) begin
        arg_val = acc[i*SUM_BW +: SUM_BW];
        arg_idx = IDX_BW'(i);
      end
    end
  end

  // A write coincident with batch_finish still lands, since state is still CAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) mem[r] <= '0;
    end else if (accept) begin
      for (int r = 0; r < ROWS; r++) mem[r] <= '0;
    end else if (write) begin
      for (int i = 0; i < Q; i++) begin
        if (bus.pro_bytemask[i])
          mem[bus.pro_waddr][i*PRO_BW +: PRO_BW] <= bus.pro_wdata[i*PRO_BW +: PRO_BW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt     <= '0;
      acc         <= '0;
      sum_q       <= '0;
      best_idx_q  <= '0;
      best_val_q  <= '0;
      out_valid_q <= 1'b0;
      drop_err_q  <= 1'b0;
    end else if (en) begin
      case (state)
        SUM: begin
          acc     <= acc_nxt;
          row_cnt <= row_cnt + 1'b1;
        end
        BEST: begin
          sum_q      <= acc;
          best_idx_q <= arg_idx;
          best_val_q <= arg_val;
        end
        DONE: begin
          // First DONE cycle registers out_valid; the handshake then clears acc.
          if (accept) begin
            acc         <= '0;
            out_valid_q <= 1'b0;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: ;
      endcase
      if (bus.wen && (state != CAP)) drop_err_q <= 1'b1;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum_out   = sum_q;
  assign bus.best_idx  = best_idx_q;
  assign bus.best_val  = best_val_q;
  assign bus.busy      = (state != CAP);
  assign bus.drop_err  = drop_err_q;
endmodule

// File: tb/tb_pro_accum.sv
// tb/tb_pro_accum.sv - self-checking bench for pro_accum
module tb_pro_accum;
  localparam int Q      = 16;
  localparam int PRO_BW = 8;
  localparam int AW     = 4;
  localparam int SUM_BW = 12;
  localparam int ROWS   = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;

  pro_accum_if #(.Q(Q), .PRO_BW(PRO_BW), .PRO_ADDR_SPACE(AW), .SUM_BW(SUM_BW), .IDX_BW(4)) bus();

  pro_accum #(.Q(Q), .PRO_BW(PRO_BW), .PRO_ADDR_SPACE(AW), .SUM_BW(SUM_BW), .IDX_BW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int mm [ROWS][Q];

  typedef struct {
    int la;
    int va;
    int lb;
    int vb;
    int exp_idx;
    int exp_val;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int i = 0; i < Q; i++) mm[r][i] = 0;
  endtask

  function automatic int model_tot(input int lane);
    int s = 0;
    for (int r = 0; r < ROWS; r++) s += mm[r][lane];
    return s % 4096;
  endfunction

  function automatic int model_best_idx();
    int b = 0;
    for (int i = 1; i < Q; i++) if (model_tot(i) > model_tot(b)) b = i;
    return b;
  endfunction

  function automatic int dut_lane(input int lane);
    logic [SUM_BW-1:0] v;
    v = bus.sum_out[lane*SUM_BW +: SUM_BW];
    return int'(v);
  endfunction

  // One write cycle; the model follows only when the DUT is expected to accept it.
  task automatic wr(input int row, input logic [15:0] mask, input logic [127:0] data, input bit bf);
    bus.wen          = 1'b1;
    bus.pro_waddr    = AW'(row);
    bus.pro_bytemask = mask;
    bus.pro_wdata    = data;
    bus.batch_finish = bf;
    if (en) begin
      for (int i = 0; i < Q; i++)
        if (mask[i]) mm[row][i] = int'(data[i*PRO_BW +: PRO_BW]);
    end
    step();
    bus.wen          = 1'b0;
    bus.batch_finish = 1'b0;
    bus.pro_bytemask = '0;
  endtask

  task automatic start_batch();
    bus.batch_finish = 1'b1;
    step();
    bus.batch_finish = 1'b0;
    chk("busy_in_sum", longint'(bus.busy), 1);
  endtask

  // Counts cycles from the batch_finish edge to out_valid, optionally gating en
  // and injecting a write that must be dropped.
  task automatic wait_valid(input int exp_lat, input int gate_at, input int gate_len, input int drop_at);
    int n = 0;
    while (!bus.out_valid && n < 60) begin
      en = !(n >= gate_at && n < gate_at + gate_len);
      if (n == drop_at) begin
        bus.wen          = 1'b1;
        bus.pro_waddr    = '0;
        bus.pro_bytemask = '1;
        bus.pro_wdata    = '1;
      end else begin
        bus.wen          = 1'b0;
        bus.pro_bytemask = '0;
      end
      step();
      n++;
    end
    en               = 1'b1;
    bus.wen          = 1'b0;
    bus.pro_bytemask = '0;
    chk("latency", n, exp_lat);
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_valid"}, longint'(bus.out_valid), 1);
    for (int i = 0; i < Q; i++)
      chk($sformatf("%s_lane%0d", tag, i), dut_lane(i), model_tot(i));
    chk({tag, "_best_idx"}, longint'(bus.best_idx), model_best_idx());
    chk({tag, "_best_val"}, longint'(bus.best_val), model_tot(model_best_idx()));
  endtask

  task automatic accept();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("valid_drop", longint'(bus.out_valid), 0);
    chk("busy_after_accept", longint'(bus.busy), 0);
    model_clear();
  endtask

  task automatic fill_inc_rows();
    logic [127:0] d;
    for (int i = 0; i < Q; i++) d[i*PRO_BW +: PRO_BW] = 8'(i + 1);
    for (int r = 0; r < ROWS; r++) wr(r, 16'hFFFF, d, 1'b0);
  endtask

  initial begin
    logic [127:0] d;
    int bi, bv;

    tbl[0] = '{la: 2,  va: 255, lb: 9,  vb: 255, exp_idx: 2,  exp_val: 4080};
    tbl[1] = '{la: 5,  va: 10,  lb: 3,  vb: 20,  exp_idx: 3,  exp_val: 320};
    tbl[2] = '{la: 0,  va: 0,   lb: 0,  vb: 0,   exp_idx: 0,  exp_val: 0};
    tbl[3] = '{la: 15, va: 255, lb: 14, vb: 254, exp_idx: 15, exp_val: 4080};
    tbl[4] = '{la: 1,  va: 100, lb: 12, vb: 100, exp_idx: 1,  exp_val: 1600};
    tbl[5] = '{la: 7,  va: 3,   lb: 7,  vb: 9,   exp_idx: 7,  exp_val: 144};

    bus.wen          = 1'b0;
    bus.pro_waddr    = '0;
    bus.pro_bytemask = '0;
    bus.pro_wdata    = '0;
    bus.batch_finish = 1'b0;
    bus.out_ready    = 1'b0;
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid",    longint'(bus.out_valid), 0);
    chk("rst_sum",      longint'(bus.sum_out != '0), 0);
    chk("rst_best_idx", longint'(bus.best_idx), 0);
    chk("rst_best_val", longint'(bus.best_val), 0);
    chk("rst_busy",     longint'(bus.busy), 0);
    chk("rst_drop_err", longint'(bus.drop_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    step();

    // Full-row writes, lane i = i+1.
    fill_inc_rows();
    start_batch();
    wait_valid(18, -1, 0, -1);
    check_out("full");
    chk("full_best_idx_abs", longint'(bus.best_idx), 15);
    chk("full_best_val_abs", longint'(bus.best_val), 256);
    chk("full_lane0_abs", dut_lane(0), 16);
    accept();

    // Masked overwrite on row 3.
    wr(3, 16'hFFFF, {16{8'd10}}, 1'b0);
    wr(3, 16'h0001, 128'd200, 1'b0);
    start_batch();
    wait_valid(18, -1, 0, -1);
    check_out("mask");
    chk("mask_lane0_abs", dut_lane(0), 200);
    chk("mask_lane1_abs", dut_lane(1), 10);
    chk("mask_best_idx_abs", longint'(bus.best_idx), 0);
    accept();

    // Table-driven batches with a 5-cycle stall before acceptance.
    for (int t = 0; t < 6; t++) begin
      d = '0;
      d[tbl[t].la*PRO_BW +: PRO_BW] = 8'(tbl[t].va);
      d[tbl[t].lb*PRO_BW +: PRO_BW] = 8'(tbl[t].vb);
      for (int r = 0; r < ROWS; r++) wr(r, 16'hFFFF, d, 1'b0);
      start_batch();
      wait_valid(18, -1, 0, -1);
      check_out($sformatf("tbl%0d", t));
      chk($sformatf("tbl%0d_idx", t), longint'(bus.best_idx), tbl[t].exp_idx);
      chk($sformatf("tbl%0d_val", t), longint'(bus.best_val), tbl[t].exp_val);
      for (int s = 0; s < 5; s++) begin
        step();
        chk($sformatf("tbl%0d_hold_valid", t), longint'(bus.out_valid), 1);
        chk($sformatf("tbl%0d_hold_val", t), longint'(bus.best_val), tbl[t].exp_val);
        chk($sformatf("tbl%0d_hold_idx", t), longint'(bus.best_idx), tbl[t].exp_idx);
      end
      accept();
    end

    // Write coincident with batch_finish, plus a dropped write during SUM.
    chk("drop_err_before", longint'(bus.drop_err), 0);
    d = '0;
    d[4*PRO_BW +: PRO_BW] = 8'd7;
    wr(15, 16'h0010, d, 1'b1);
    wait_valid(18, -1, 0, 3);
    check_out("simul");
    chk("simul_lane4_abs", dut_lane(4), 7);
    chk("simul_lane0_abs", dut_lane(0), 0);
    chk("drop_err_set", longint'(bus.drop_err), 1);
    accept();

    // en gated 3 cycles in SUM: latency 21, same totals as ungated run.
    fill_inc_rows();
    start_batch();
    wait_valid(21, 2, 3, -1);
    check_out("gate");
    chk("gate_lane15_abs", dut_lane(15), 256);
    chk("gate_valid_en_low", longint'(bus.out_valid), 1);
    accept();

    // Randomized batches against the model; some writes arrive with en low.
    for (int b = 0; b < 6; b++) begin
      int nw;
      nw = int'($urandom_range(5, 30));
      for (int w = 0; w < nw; w++) begin
        logic [127:0] rd;
        logic [15:0]  rm;
        for (int k = 0; k < 4; k++) rd[k*32 +: 32] = $urandom;
        rm = 16'($urandom);
        en = ($urandom_range(0, 3) != 0);
        wr(int'($urandom_range(0, ROWS - 1)), rm, rd, 1'b0);
        en = 1'b1;
      end
      start_batch();
      wait_valid(18, -1, 0, -1);
      check_out($sformatf("rnd%0d", b));
      repeat ($urandom_range(0, 3)) step();
      accept();
    end
    chk("drop_err_sticky", longint'(bus.drop_err), 1);

    // Asynchronous reset at SUM cycle 5 discards the batch.
    for (int r = 0; r < ROWS; r++) wr(r, 16'hFFFF, {16{8'd50}}, 1'b0);
    start_batch();
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",     longint'(bus.busy), 0);
    chk("mid_rst_valid",    longint'(bus.out_valid), 0);
    chk("mid_rst_drop_err", longint'(bus.drop_err), 0);
    chk("mid_rst_best_val", longint'(bus.best_val), 0);
    chk("mid_rst_sum",      longint'(bus.sum_out != '0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    step();
    wr(0, 16'h0001, 128'd1, 1'b0);
    start_batch();
    wait_valid(18, -1, 0, -1);
    check_out("post_rst");
    chk("post_rst_lane1_abs", dut_lane(1), 0);
    bi = int'(bus.best_idx);
    bv = int'(bus.best_val);
    chk("post_rst_best_abs", bi * 10000 + bv, 1);
    accept();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
